// File: rtl/pd_pkg.sv
// Shared arbiter types: FSM state encoding and requester identifiers.
`timescale 1ns/1ps
package pd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_OUT = 2'd1,
    D_OUT = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports, 1 access/cycle.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AWIDTH         = 32,
  parameter int DWIDTH         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [AWIDTH-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DWIDTH-1:0] f_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  input  logic [DWIDTH-1:0] mem_rdata_i
);
  import pd_pkg::*;

  arb_state_e state_q, state_d;
  req_id_e    sel_s;
  logic       starve_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  // Fetch has waited through a full data burst and must win the next slot.
  always_comb begin
    starve_s = (burst_cnt_q == CW'(MAX_DATA_BURST)) && f_req_i;
  end

  // Count data grants that pass over a waiting fetch, saturating at the limit.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (f_gnt_o || !f_req_i) begin
      burst_cnt_d = '0;
    end else if (d_gnt_o && (burst_cnt_q != CW'(MAX_DATA_BURST))) begin
      burst_cnt_d = burst_cnt_q + CW'(1);
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
  end
`else
  // Strict data-over-fetch: fetch never overrides a data request.
  always_comb begin
    starve_s = 1'b0;
  end
`endif

  // Grant selection; reset gates grants so the memory side stays quiet while rst is low.
  always_comb begin
    f_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
    if (rst) begin
      if (d_req_i && !starve_s) begin
        d_gnt_o = 1'b1;
      end else if (f_req_i) begin
        f_gnt_o = 1'b1;
      end else begin
        d_gnt_o = 1'b0;
      end
    end else begin
      f_gnt_o = 1'b0;
    end
  end

  // Drive the memory port from whichever requester holds the grant.
  always_comb begin
    sel_s       = d_gnt_o ? REQ_DATA : REQ_FETCH;
    mem_ren_o   = f_gnt_o | (d_gnt_o & ~d_we_i);
    mem_wen_o   = d_gnt_o & d_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (f_gnt_o || d_gnt_o) begin
      mem_addr_o = (sel_s == REQ_DATA) ? d_addr_i : f_addr_i;
      if (mem_wen_o) begin
        mem_wdata_o = d_wdata_i;
      end else begin
        mem_wdata_o = '0;
      end
    end else begin
      mem_addr_o = '0;
    end
  end

  // Next state: only a read leaves a response outstanding for the following cycle.
  always_comb begin
    state_d = IDLE;
    if (f_gnt_o) begin
      state_d = F_OUT;
    end else if (d_gnt_o && !d_we_i) begin
      state_d = D_OUT;
    end else begin
      state_d = IDLE;
    end
  end

  // Return path: memory data is forwarded to the port whose read is outstanding.
  always_comb begin
    f_rvalid_o = 1'b0;
    d_rvalid_o = 1'b0;
    f_rdata_o  = '0;
    d_rdata_o  = '0;
    case (state_q)
      F_OUT: begin
        f_rvalid_o = 1'b1;
        f_rdata_o  = mem_rdata_i;
      end
      D_OUT: begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = mem_rdata_i;
      end
      default: begin
        f_rvalid_o = 1'b0;
      end
    endcase
  end

  // State registers; an async reset drops any outstanding read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
`ifdef ARB_STARVE_GUARD_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 32, the address width.
REQ-002 The block SHALL have parameter DWIDTH, default 32, the data width.
REQ-003 The block SHALL have parameter MAX_DATA_BURST, default 4, the maximum consecutive data grants while fetch waits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port f_req_i, input, 1 bit: fetch read request.
REQ-007 The block SHALL have port f_addr_i, input, AWIDTH bits: fetch address (PC).
REQ-008 The block SHALL have port f_gnt_o, output, 1 bit: fetch request accepted this cycle.
REQ-009 The block SHALL have port f_rvalid_o, output, 1 bit: fetch read data valid.
REQ-010 The block SHALL have port f_rdata_o, output, DWIDTH bits: fetch read data (instruction).
REQ-011 The block SHALL have port d_req_i, input, 1 bit: data request.
REQ-012 The block SHALL have port d_we_i, input, 1 bit: data write (1) or read (0).
REQ-013 The block SHALL have port d_addr_i, input, AWIDTH bits: data address.
REQ-014 The block SHALL have port d_wdata_i, input, DWIDTH bits: store data.
REQ-015 The block SHALL have port d_gnt_o, output, 1 bit: data request accepted this cycle.
REQ-016 The block SHALL have port d_rvalid_o, output, 1 bit: data read data valid.
REQ-017 The block SHALL have port d_rdata_o, output, DWIDTH bits: data read data.
REQ-018 The block SHALL have port mem_addr_o, output, AWIDTH bits: memory address.
REQ-019 The block SHALL have port mem_wdata_o, output, DWIDTH bits: memory write data.
REQ-020 The block SHALL have port mem_ren_o, output, 1 bit: memory read enable.
REQ-021 The block SHALL have port mem_wen_o, output, 1 bit: memory write enable.
REQ-022 The block SHALL have port mem_rdata_i, input, DWIDTH bits: memory read data, valid the cycle after mem_ren_o.

Function
REQ-023 Grants SHALL be combinational from the requests and current state; at most one of f_gnt_o/d_gnt_o SHALL be high per cycle.
REQ-024 A requester SHALL hold req and addr/we/wdata stable until its gnt; the grant cycle drives mem_* from the granted port and completes the handshake.
REQ-025 mem_ren_o SHALL equal (f_gnt_o | (d_gnt_o & ~d_we_i)), mem_wen_o SHALL equal (d_gnt_o & d_we_i), and mem_addr_o/mem_wdata_o SHALL be 0 when no grant is given.
REQ-026 The FSM SHALL have states IDLE, F_OUT (fetch read outstanding) and D_OUT (data read outstanding); a read grant SHALL move to F_OUT/D_OUT; a write or no grant SHALL move to IDLE.
REQ-027 In F_OUT, f_rvalid_o SHALL be 1 with f_rdata_o=mem_rdata_i; in D_OUT, d_rvalid_o SHALL be 1 with d_rdata_o=mem_rdata_i; otherwise rvalid SHALL be 0 and rdata SHALL be 0.
REQ-028 A new grant SHALL be allowed in the same cycle a response returns, giving a throughput of 1 access/cycle and a read latency of 1 cycle.
REQ-029 Default priority SHALL be data over fetch when both request.
REQ-030 burst_cnt SHALL increment on each d_gnt_o while f_req_i=1, clear on f_gnt_o or when f_req_i=0, and saturate at MAX_DATA_BURST.
REQ-031 A data store followed by a fetch to the same address SHALL return the new data.

Reset
REQ-032 While rst=0, the block SHALL hold state=IDLE, burst_cnt=0, all gnt/rvalid/ren/wen outputs=0 and all data/address outputs=0, asynchronously.
REQ-033 On reset mid-transaction, the outstanding read SHALL be dropped with no rvalid after release; the first grant is possible in the first cycle with rst=1.

Configuration
REQ-034 With ARB_STARVE_GUARD_EN defined, when burst_cnt==MAX_DATA_BURST and f_req_i=1, fetch SHALL win over data for exactly one grant.
REQ-035 Without ARB_STARVE_GUARD_EN, burst_cnt SHALL not exist and priority SHALL be strict data-over-fetch.

Structure
REQ-036 The shared package pd_pkg SHALL hold the arb_state_e enum (IDLE, F_OUT, D_OUT) and the requester-id typedef (REQ_FETCH, REQ_DATA).
REQ-037 The block SHALL be a single module with no sub-module; the FSM and counter SHALL live inline.

Verification
REQ-038 The bench SHALL apply f_req with f_addr=0x01000000 alone -> f_gnt same cycle, f_rvalid next cycle, f_rdata=memory word.
REQ-039 The bench SHALL apply f_req and d_req (read 0x01000100) in the same cycle -> d_gnt first, f_gnt the next cycle, responses on consecutive cycles.
REQ-040 The bench SHALL apply a d_we store of 0xDEADBEEF to 0x01000010, then a fetch of 0x01000010 -> mem_wen one cycle with no rvalid, then f_rdata=0xDEADBEEF.
REQ-041 The bench SHALL hold f_req and d_req high continuously with the guard on -> grant pattern D,D,D,D,F repeating; with the guard off -> D forever.
REQ-042 The bench SHALL assert rst low in F_OUT -> all outputs 0 immediately and no f_rvalid after release.
